ram_clr: RTL and testbench

Parametrised successor to the fixed-size RAM8…RAM16K family: a single word-addressable RAM of `WIDTH`-bit words and `2**ADDR_BITS` depth, with the same `in`/`load`/`address`/`out` contract. It adds a sequential clear engine. The engine zeroes every word after reset and on request, and a `busy` flag gates access while a sweep runs. It serves as the memory primitive for the data-memory and scratch-RAM instances in the CPU build.

---
 rtl/ram_clr_pkg.sv | 13 +
 rtl/ram_clr_seq.sv | 55 +++++
 rtl/ram_clr.sv | 52 +++++
 tb/tb_ram_clr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_clr_pkg.sv
// Shared definitions for the clearable RAM: sweep FSM state encoding and
// the default geometry used by top-level instantiations.
package ram_clr_pkg;

  typedef enum logic {
    RAM_ST_IDLE  = 1'b0,
    RAM_ST_CLEAR = 1'b1
  } ram_st_e;

  localparam int RAM_WIDTH_DEF     = 16;
  localparam int RAM_ADDR_BITS_DEF = 3;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear-sweep sequencer: walks cnt through every address once after reset
// or a clear request, then parks in IDLE.
module ram_clr_seq
  import ram_clr_pkg::*;
#(
  parameter int ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr
);

  localparam logic [ADDR_BITS-1:0] LAST = '1;

  ram_st_e              state, state_nxt;
  logic [ADDR_BITS-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RAM_ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt wraps to zero on its own after LAST, so the exit edge needs no reload
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RAM_ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = RAM_ST_IDLE;
      end
      RAM_ST_IDLE: begin
        if (clear) begin
          state_nxt = RAM_ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state == RAM_ST_CLEAR);
    clr_we   = busy;
    clr_addr = cnt;
  end

endmodule

// File: rtl/ram_clr.sv
// Word-addressable RAM with a built-in zeroing sweep; user access is
// locked out while the sweep runs.
module ram_clr
  import ram_clr_pkg::*;
#(
  parameter int WIDTH     = RAM_WIDTH_DEF,
  parameter int ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;

  ram_clr_seq #(
    .ADDR_BITS (ADDR_BITS)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Sweep owns the write port; a user write is dropped if clear arrives with it
  always_comb begin
    wr_en   = clr_we | (load & ~clear & ~busy);
    wr_addr = clr_we ? clr_addr : address;
    wr_data = clr_we ? '0 : in;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign out = busy ? '0 : mem[address];

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench for ram_clr: a 16x8 instance and an 8x64 instance checked
// every cycle against a word-array model plus hand-computed expectations.
module tb_ram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ra = 1'b0, rb = 1'b0;
  logic [15:0] a_in = '0;
  logic        a_load = 1'b0, a_clear = 1'b0;
  logic [2:0]  a_addr = '0;
  logic [15:0] a_out;
  logic        a_busy;
  logic [7:0]  b_in = '0;
  logic        b_load = 1'b0, b_clear = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [7:0]  b_out;
  logic        b_busy;

  ram_clr #(.WIDTH(16), .ADDR_BITS(3)) dut_a (
    .clk(clk), .reset(ra), .in(a_in), .load(a_load), .address(a_addr),
    .clear(a_clear), .out(a_out), .busy(a_busy)
  );

  ram_clr #(.WIDTH(8), .ADDR_BITS(6)) dut_b (
    .clk(clk), .reset(rb), .in(b_in), .load(b_load), .address(b_addr),
    .clear(b_clear), .out(b_out), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: a word array plus the number of sweep edges still owed
  logic [15:0] ma [8];
  int          la = 0;
  logic [7:0]  mb [64];
  int          lb = 0;

  always @(posedge clk or posedge ra) begin
    if (ra) la <= 8;
    else if (la > 0) begin
      ma[8 - la] <= '0;
      la         <= la - 1;
    end else if (a_clear) la <= 8;
    else if (a_load) ma[a_addr] <= a_in;
  end

  always @(posedge clk or posedge rb) begin
    if (rb) lb <= 64;
    else if (lb > 0) begin
      mb[64 - lb] <= '0;
      lb          <= lb - 1;
    end else if (b_clear) lb <= 64;
    else if (b_load) mb[b_addr] <= b_in;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", 32'(a_busy), 32'(la > 0));
      chk("a_out", 32'(a_out), (la > 0) ? 32'h0 : 32'(ma[a_addr]));
      chk("b_busy", 32'(b_busy), 32'(lb > 0));
      chk("b_out", 32'(b_out), (lb > 0) ? 32'h0 : 32'(mb[b_addr]));
    end
  end

  task automatic a_sweep(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (!a_busy) break;
    end
  endtask

  task automatic a_write(input logic [2:0] ad, input logic [15:0] d);
    @(negedge clk); #1;
    a_addr = ad; a_in = d; a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic a_read(input string name, input logic [2:0] ad, input logic [15:0] exp);
    a_addr = ad; #1;
    chk(name, 32'(a_out), 32'(exp));
  endtask

  task automatic a_clear_pulse();
    @(negedge clk); #1;
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int n;
    #1 ra = 1'b1; rb = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(a_busy), 32'h1);
    chk("rst_out", 32'(a_out), 32'h0);

    // Reset release: 8-edge sweep, then every word reads zero
    @(negedge clk);
    ra = 1'b0; rb = 1'b0;
    a_sweep(n);
    chk("init_sweep_len", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) a_read("init_zero", 3'(i), 16'h0000);

    // Write/read-back, including read-before-edge on the same address
    @(negedge clk); #1;
    a_addr = 3'd5; a_in = 16'hBEEF; a_load = 1'b1; #1;
    chk("rbw_addr5", 32'(a_out), 32'h0000);
    @(posedge clk); #1;
    a_load = 1'b0;
    chk("post_edge5", 32'(a_out), 32'h0000BEEF);
    a_write(3'd2, 16'h1234);
    a_read("rd5", 3'd5, 16'hBEEF);
    a_read("rd2", 3'd2, 16'h1234);

    // clear beats load in the same idle cycle
    @(negedge clk); #1;
    a_addr = 3'd7; a_in = 16'hFFFF; a_load = 1'b1; a_clear = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0; a_clear = 1'b0;
    chk("clr_busy", 32'(a_busy), 32'h1);
    a_sweep(n);
    chk("clr_sweep_len", 32'(n), 32'd8);
    a_read("clr_rd5", 3'd5, 16'h0000);
    a_read("clr_rd7", 3'd7, 16'h0000);
    a_read("clr_rd2", 3'd2, 16'h0000);

    // load and clear issued late in a sweep are ignored
    a_clear_pulse();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (n == 6) begin
        a_addr = 3'd3; a_in = 16'hAAAA; a_load = 1'b1; a_clear = 1'b1;
      end
      if (n == 7) begin
        a_load = 1'b0; a_clear = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!a_busy) break;
    end
    a_load = 1'b0; a_clear = 1'b0;
    chk("busy_ign_len", 32'(n), 32'd8);
    a_read("busy_ign_rd3", 3'd3, 16'h0000);

    // Asynchronous reset pulse between edges mid-sweep restarts it
    a_write(3'd4, 16'h1111);
    a_read("pre_rst_rd4", 3'd4, 16'h1111);
    a_clear_pulse();
    repeat (3) @(posedge clk);
    #3 ra = 1'b1;
    #1;
    chk("midrst_busy", 32'(a_busy), 32'h1);
    chk("midrst_out", 32'(a_out), 32'h0);
    ra = 1'b0;
    a_sweep(n);
    chk("midrst_sweep_len", 32'(n), 32'd8);
    a_read("midrst_rd4", 3'd4, 16'h0000);

    // 8x64 instance: 64-edge sweep, top address write, address 0 untouched
    @(negedge clk); #1;
    rb = 1'b1; #1;
    chk("b_rst_busy", 32'(b_busy), 32'h1);
    rb = 1'b0;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      n++;
      if (!b_busy) break;
    end
    chk("b_sweep_len", 32'(n), 32'd64);
    @(negedge clk); #1;
    b_addr = 6'd63; b_in = 8'hA5; b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
    chk("b_rd63", 32'(b_out), 32'h000000A5);
    b_addr = 6'd0; #1;
    chk("b_rd0", 32'(b_out), 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
